// File: rtl/pe_regfile_acc_if.sv
// Operand-fetch side bundle of the PE register file: write port, packed read ports and the
// clear-sequencer handshake.
interface pe_regfile_acc_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_RPORTS = 2
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  logic                             we;
  logic                             wmode;
  logic [ADDR_WIDTH-1:0]            waddr;
  logic [DATA_WIDTH-1:0]            wdata;
  logic [NUM_RPORTS-1:0]            rd_en;
  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata;
  logic [NUM_RPORTS-1:0]            rvalid;
  logic                             clr_start;
  logic                             clr_busy;
  logic                             clr_done;
  logic                             wr_drop;

  modport master (
    output we, wmode, waddr, wdata, rd_en, raddr, clr_start,
    input  rdata, rvalid, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  we, wmode, waddr, wdata, rd_en, raddr, clr_start,
    output rdata, rvalid, clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/pe_regfile_acc.sv
// PE-local register file: registered multi-port reads with optional write forwarding,
// overwrite or signed saturating-accumulate writes, and a one-entry-per-cycle clear sequencer.
module pe_regfile_acc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_RPORTS = 2,
  parameter bit          BYPASS     = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  pe_regfile_acc_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  // One extra bit so that a power-of-two DEPTH is representable in range compares.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  waddr_ok;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH:0]   acc_sum;
  logic [DATA_WIDTH-1:0] acc_sat;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  wr_drop_q;

  logic [ADDR_WIDTH-1:0] rd_addr  [NUM_RPORTS];
  logic [DATA_WIDTH-1:0] rd_val   [NUM_RPORTS];
  logic [DATA_WIDTH-1:0] rdata_q  [NUM_RPORTS];
  logic [NUM_RPORTS-1:0] rvalid_q;

  // Writes are accepted only while the clear sequencer is idle.
  assign waddr_ok = {1'b0, bus.waddr} < DEPTH_EXT;
  assign wr_en    = bus.we && waddr_ok && (state_q == StIdle);
  assign wr_old   = waddr_ok ? mem_q[bus.waddr] : '0;

  always_comb begin
    acc_sum = {wr_old[DATA_WIDTH-1], wr_old} + {bus.wdata[DATA_WIDTH-1], bus.wdata};
    acc_sat = acc_sum[DATA_WIDTH-1:0];
    // Sign bits disagree only on signed overflow; the extra MSB gives the true sign.
    if (acc_sum[DATA_WIDTH] != acc_sum[DATA_WIDTH-1]) begin
      acc_sat = acc_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    wr_val = bus.wmode ? acc_sat : bus.wdata;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (bus.clr_start) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = StDone;
          idx_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= bus.we && !wr_en;
    end
  end

  // A write in the clr_start cycle lands first; the sweep then overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[idx_q] <= '0;
    end else if (wr_en) begin
      mem_q[bus.waddr] <= wr_val;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rd_addr[p] = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val[p]  = '0;
      if ({1'b0, rd_addr[p]} < DEPTH_EXT) begin
        if (BYPASS && wr_en && (bus.waddr == rd_addr[p])) begin
          rd_val[p] = wr_val;
        end else begin
          rd_val[p] = mem_q[rd_addr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      for (int p = 0; p < NUM_RPORTS; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      rvalid_q <= bus.rd_en;
      for (int p = 0; p < NUM_RPORTS; p++) begin
        if (bus.rd_en[p]) begin
          rdata_q[p] <= rd_val[p];
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
    end
  end

  assign bus.rvalid   = rvalid_q;
  assign bus.wr_drop  = wr_drop_q;
  assign bus.clr_busy = (state_q == StClear);
  assign bus.clr_done = (state_q == StDone);

endmodule

// File: tb/tb_pe_regfile_acc.sv
// Directed bench for pe_regfile_acc: a 16-deep bypassing instance driven through a read
// scoreboard, plus a 12-deep non-bypassing instance for range and forwarding-off cases.
module tb_pe_regfile_acc;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_regfile_acc_if #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_RPORTS(NP)) bus_a ();
  pe_regfile_acc_if #(.DATA_WIDTH(DW), .DEPTH(12), .NUM_RPORTS(NP)) bus_b ();

  pe_regfile_acc #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_RPORTS(NP), .BYPASS(1'b1)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  pe_regfile_acc #(.DATA_WIDTH(DW), .DEPTH(12), .NUM_RPORTS(NP), .BYPASS(1'b0)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cnt;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [NP-1:0] exp_rv = '0;
  logic exp_drop = 1'b0;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fillv(input int i);
    return DW'(32'h0111 * i + 32'h0101);
  endfunction

  task automatic idle_a();
    bus_a.we = 1'b0; bus_a.wmode = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0;
    bus_a.rd_en = '0; bus_a.raddr = '0; bus_a.clr_start = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.we = 1'b0; bus_b.wmode = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0;
    bus_b.rd_en = '0; bus_b.raddr = '0; bus_b.clr_start = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m,
                    input logic drop);
    bus_a.we = 1'b1; bus_a.waddr = a; bus_a.wdata = d; bus_a.wmode = m;
    exp_drop = drop;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus_a.rd_en[p] = 1'b1;
    bus_a.raddr[p*AW +: AW] = a;
    exp_rv[p] = 1'b1;
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Clock one cycle on instance A, then score every port that reports new data.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rvalid", bus_a.rvalid, exp_rv);
    chk("wr_drop", bus_a.wr_drop, exp_drop);
    if (bus_a.rvalid[0] && q0.size() > 0) chk("rdata0", bus_a.rdata[DW-1:0], q0.pop_front());
    if (bus_a.rvalid[1] && q1.size() > 0) chk("rdata1", bus_a.rdata[2*DW-1:DW], q1.pop_front());
    exp_rv = '0;
    exp_drop = 1'b0;
    idle_a();
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_a();
    idle_b();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", bus_a.rdata, 0);
    chk("rst_rvalid", bus_a.rvalid, 0);
    chk("rst_busy", bus_a.clr_busy, 0);
    chk("rst_done", bus_a.clr_done, 0);
    chk("rst_drop", bus_a.wr_drop, 0);
    rst_n = 1'b1;

    // Overwrite and registered read, then hold with rd_en low
    wr(3, 16'h1234, 1'b0, 1'b0); tick();
    rd(0, 3, 16'h1234); tick();
    tick();
    chk("hold_rdata0", bus_a.rdata[DW-1:0], 16'h1234);

    // Saturating accumulate: positive clamp, negative clamp, plain sum (forwarded)
    wr(5, 16'h7FF0, 1'b0, 1'b0); tick();
    wr(5, 16'h0020, 1'b1, 1'b0); tick();
    wr(6, 16'h8005, 1'b0, 1'b0); tick();
    wr(6, 16'hFFF0, 1'b1, 1'b0); tick();
    wr(7, 16'h0010, 1'b0, 1'b0); tick();
    wr(7, 16'hFFF8, 1'b1, 1'b0); rd(0, 7, 16'h0008); rd(1, 6, 16'h8000); tick();
    rd(0, 5, 16'h7FFF); rd(1, 7, 16'h0008); tick();

    // Forwarding to both ports on the same address
    wr(2, 16'h1111, 1'b0, 1'b0); tick();
    wr(2, 16'hABCD, 1'b0, 1'b0); rd(0, 2, 16'hABCD); rd(1, 2, 16'hABCD); tick();

    // Full clear with concurrent write/read in the start cycle
    for (int i = 0; i < 16; i++) begin
      wr(i[AW-1:0], fillv(i), 1'b0, 1'b0); tick();
    end
    wr(0, 16'h5555, 1'b0, 1'b0); rd(0, 0, 16'h5555); bus_a.clr_start = 1'b1; tick();
    for (int k = 0; k < 16; k++) begin
      chk("clr_busy", bus_a.clr_busy, 1);
      chk("clr_done_early", bus_a.clr_done, 0);
      rd(1, 15, fillv(15));
      if (k >= 1) rd(0, AW'(k - 1), 16'h0000);
      if (k == 2) bus_a.clr_start = 1'b1;
      if (k == 4) wr(9, 16'hDEAD, 1'b0, 1'b1);
      tick();
    end
    chk("done_pulse", bus_a.clr_done, 1);
    chk("done_busy", bus_a.clr_busy, 0);
    wr(1, 16'hBEEF, 1'b0, 1'b1); rd(0, 1, 16'h0000); bus_a.clr_start = 1'b1; tick();
    chk("post_done", bus_a.clr_done, 0);
    chk("post_busy", bus_a.clr_busy, 0);
    for (int i = 0; i < 16; i += 2) begin
      rd(0, AW'(i), 16'h0000); rd(1, AW'(i + 1), 16'h0000); tick();
    end

    // Non-bypassing 12-deep instance: old data on collision, out-of-range write/read
    bus_b.we = 1'b1; bus_b.waddr = 2; bus_b.wdata = 16'h1111; step_b();
    bus_b.wdata = 16'hABCD; bus_b.rd_en = 2'b11; bus_b.raddr = {4'd2, 4'd2}; step_b();
    chk("b_old0", bus_b.rdata[DW-1:0], 16'h1111);
    chk("b_old1", bus_b.rdata[2*DW-1:DW], 16'h1111);
    bus_b.waddr = 13; bus_b.wdata = 16'h7777; bus_b.rd_en = 2'b01; step_b();
    chk("b_new0", bus_b.rdata[DW-1:0], 16'hABCD);
    chk("b_drop", bus_b.wr_drop, 1);
    bus_b.we = 1'b0; bus_b.rd_en = 2'b11; bus_b.raddr = {4'd1, 4'd14}; step_b();
    chk("b_oor_rvalid", bus_b.rvalid, 2'b11);
    chk("b_oor_rdata", bus_b.rdata[DW-1:0], 0);
    chk("b_alias1", bus_b.rdata[2*DW-1:DW], 0);
    chk("b_nodrop", bus_b.wr_drop, 0);
    bus_b.raddr = {4'd5, 4'd2}; step_b();
    chk("b_keep2", bus_b.rdata[DW-1:0], 16'hABCD);
    chk("b_alias5", bus_b.rdata[2*DW-1:DW], 0);
    idle_b(); bus_b.clr_start = 1'b1; step_b();
    idle_b();
    cnt = 0;
    while (bus_b.clr_busy && cnt < 40) begin step_b(); cnt++; end
    chk("b_clr_len", cnt, 12);
    chk("b_clr_done", bus_b.clr_done, 1);

    // Reset in the middle of a clear sweep
    for (int i = 0; i < 16; i++) begin
      wr(i[AW-1:0], fillv(i), 1'b0, 1'b0); tick();
    end
    bus_a.clr_start = 1'b1; tick();
    repeat (4) tick();
    rd(0, 15, fillv(15)); wr(3, 16'h0F0F, 1'b0, 1'b1); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", bus_a.rdata, 0);
    chk("mid_rst_rvalid", bus_a.rvalid, 0);
    chk("mid_rst_busy", bus_a.clr_busy, 0);
    chk("mid_rst_drop", bus_a.wr_drop, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_done", bus_a.clr_done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i += 2) begin
      rd(0, AW'(i), 16'h0000); rd(1, AW'(i + 1), 16'h0000); tick();
    end
    bus_a.clr_start = 1'b1; tick();
    cnt = 0;
    while (bus_a.clr_busy && cnt < 40) begin tick(); cnt++; end
    chk("a_clr_len", cnt, 16);
    chk("a_clr_done", bus_a.clr_done, 1);

    chk("sb_drain", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
